// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a registered-output FIFO into a valid/ready
// stream through a 3-entry prefetch buffer and marks burst boundaries.
module fifo_stream_reader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  clear,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [1:0]            level
);

  localparam int unsigned DEPTH     = 3;
  localparam int unsigned CNT_W     = 8;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  logic [DATA_WIDTH-1:0] r_buf [DEPTH];
  logic [1:0]            r_rd_ptr;
  logic [1:0]            r_wr_ptr;
  logic [1:0]            r_level;
  logic                  r_inflight;
  logic [CNT_W-1:0]      r_beat_cnt;

  logic                  w_push;
  logic                  w_pop;
  logic [2:0]            w_occupancy;

  // Advance a buffer pointer, wrapping after the last entry.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Handshake decode and read issue; a read is only issued when the word it
  // returns is guaranteed a free slot, counting the word already in flight.
  always_comb begin
    w_push      = r_inflight;
    w_pop       = m_valid && m_ready;
    w_occupancy = 3'(r_level) + 3'(r_inflight);
    fifo_rd_en  = !rst && !fifo_empty && !clear && (w_occupancy < 3'd3);
  end

  // Stream outputs presented from the buffer head.
  always_comb begin
    m_valid = (r_level != 2'd0);
    m_data  = r_buf[r_rd_ptr];
    m_last  = m_valid && (r_beat_cnt == LAST_BEAT);
    level   = r_level;
  end

  // Pointers, occupancy, in-flight read tracking and burst beat counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr   <= 2'd0;
      r_wr_ptr   <= 2'd0;
      r_level    <= 2'd0;
      r_inflight <= 1'b0;
      r_beat_cnt <= '0;
    end else if (clear) begin
      r_rd_ptr   <= 2'd0;
      r_wr_ptr   <= 2'd0;
      r_level    <= 2'd0;
      r_inflight <= 1'b0;
      r_beat_cnt <= '0;
    end else begin
      r_inflight <= fifo_rd_en;
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop) begin
        r_rd_ptr   <= ptr_inc(r_rd_ptr);
        r_beat_cnt <= (r_beat_cnt == LAST_BEAT) ? '0 : r_beat_cnt + CNT_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 2'd1;
        2'b01:   r_level <= r_level - 2'd1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Buffer storage; a word returning during clear is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_buf[i] <= '0;
    end else if (w_push && !clear) begin
      r_buf[r_wr_ptr] <= fifo_data_out;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader: behavioural FIFO model plus a
// scoreboard of expected {last, data} beats.
`timescale 1ns/1ps
module tb_fifo_stream_reader;

  localparam int DW = 8;
  localparam int BL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_data_out;
  logic          fifo_empty;
  logic          clear;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic [1:0]    level;

  fifo_stream_reader #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst), .fifo_rd_en(fifo_rd_en), .fifo_data_out(fifo_data_out),
    .fifo_empty(fifo_empty), .clear(clear), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .level(level)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rd_cnt, hs_cnt, last_cnt, first_rd, first_hs, last_hs;
  int tb_beat = 0;
  logic tb_inflight = 1'b0;
  logic [DW-1:0] fq[$];
  logic [DW:0]   sb[$];

  // One clock cycle: sample at negedge, then update the FIFO model after the edge.
  task automatic step();
    logic rd, hs;
    logic [DW:0] e;
    @(negedge clk);
    cyc++;
    rd = fifo_rd_en && !fifo_empty;
    hs = m_valid && m_ready;
    tests++;
    if (fifo_rd_en && fifo_empty) begin
      fails++;
      $display("FAIL rd_while_empty cyc %0d: fifo_rd_en=%b required 0", cyc, fifo_rd_en);
    end
    tests++;
    if (tb_inflight && level == 2'd3 && !hs && !clear) begin
      fails++;
      $display("FAIL overflow cyc %0d: push pending with level=%0d and no pop, required no push", cyc, level);
    end
    if (rd) begin
      rd_cnt++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (hs) begin
      hs_cnt++;
      if (first_hs < 0) first_hs = cyc;
      last_hs = cyc;
      if (m_last) last_cnt++;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL beat_unexpected cyc %0d: got data=%h last=%b, required no beat", cyc, m_data, m_last);
      end else begin
        e = sb.pop_front();
        if ({m_last, m_data} !== e) begin
          fails++;
          $display("FAIL beat cyc %0d: got data=%h last=%b, required data=%h last=%b",
                   cyc, m_data, m_last, e[DW-1:0], e[DW]);
        end
      end
    end
    @(posedge clk);
    #1;
    if (rd) fifo_data_out = fq.pop_front();
    fifo_empty  = (fq.size() == 0);
    tb_inflight = rd;
  endtask

  task automatic mark();
    rd_cnt = 0; hs_cnt = 0; last_cnt = 0;
    first_rd = -1; first_hs = -1; last_hs = -1;
  endtask

  task automatic load(input int base, input int n);
    logic [DW-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = DW'(base + i);
      fq.push_back(w);
      sb.push_back({(tb_beat == BL - 1), w});
      tb_beat = (tb_beat == BL - 1) ? 0 : tb_beat + 1;
    end
    fifo_empty = (fq.size() == 0);
  endtask

  // Words still in the FIFO are the only survivors of a flush; burst restarts.
  task automatic resync();
    sb.delete();
    tb_beat = 0;
    foreach (fq[i]) begin
      sb.push_back({(tb_beat == BL - 1), fq[i]});
      tb_beat = (tb_beat == BL - 1) ? 0 : tb_beat + 1;
    end
  endtask

  task automatic drain(input int budget, input string name);
    for (int k = 0; k < budget && sb.size() != 0; k++) step();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: %0d words outstanding, required 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; m_ready = 1'b0; fifo_empty = 1'b1; fifo_data_out = '0;
    #1;
    tests++;
    if ({m_valid, m_data, m_last, fifo_rd_en, level} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: valid=%b data=%h last=%b rd_en=%b level=%0d, required all 0",
               m_valid, m_data, m_last, fifo_rd_en, level);
    end
    mark();
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    tests++;
    if (rd_cnt != 0 || m_valid !== 1'b0 || level !== 2'd0) begin
      fails++;
      $display("FAIL idle: rd pulses=%0d valid=%b level=%0d, required 0 0 0", rd_cnt, m_valid, level);
    end
  endtask

  task automatic test_stream();
    mark();
    m_ready = 1'b1;
    load(8'h01, 16);
    drain(60, "stream");
    tests++;
    if (rd_cnt != 16) begin
      fails++; $display("FAIL stream_rd_pulses: got %0d, required 16", rd_cnt);
    end
    // First beat appears the cycle after the FIFO presents the first word.
    tests++;
    if (first_hs != first_rd + 2) begin
      fails++; $display("FAIL stream_latency: first beat cyc %0d, required %0d", first_hs, first_rd + 2);
    end
    tests++;
    if (last_hs - first_hs != 15) begin
      fails++; $display("FAIL stream_gapless: span %0d, required 15", last_hs - first_hs);
    end
    tests++;
    if (last_cnt != 4) begin
      fails++; $display("FAIL stream_last_count: got %0d, required 4", last_cnt);
    end
    step(); step();
    tests++;
    if (m_valid !== 1'b0 || level !== 2'd0) begin
      fails++; $display("FAIL stream_idle_after: valid=%b level=%0d, required 0 0", m_valid, level);
    end
  endtask

  task automatic test_backpressure();
    mark();
    m_ready = 1'b0;
    load(8'h01, 8);
    for (int i = 0; i < 10; i++) step();
    tests++;
    if (rd_cnt != 3 || level !== 2'd3 || fifo_rd_en !== 1'b0) begin
      fails++;
      $display("FAIL bp_full: rd pulses=%0d level=%0d rd_en=%b, required 3 3 0", rd_cnt, level, fifo_rd_en);
    end
    tests++;
    if (m_valid !== 1'b1 || m_data !== 8'h01) begin
      fails++; $display("FAIL bp_hold: valid=%b data=%h, required 1 01", m_valid, m_data);
    end
    mark();
    m_ready = 1'b1;
    drain(40, "bp");
    tests++;
    if (hs_cnt != 8 || last_hs - first_hs != 7) begin
      fails++; $display("FAIL bp_release: beats=%0d span=%0d, required 8 7", hs_cnt, last_hs - first_hs);
    end
  endtask

  task automatic test_alternate();
    mark();
    load(8'hA0, 6);
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      m_ready = (i % 2 == 0);
      step();
    end
    tests++;
    if (sb.size() != 0 || hs_cnt != 6 || last_cnt != 1) begin
      fails++;
      $display("FAIL alt: outstanding=%0d beats=%0d lasts=%0d, required 0 6 1", sb.size(), hs_cnt, last_cnt);
    end
    m_ready = 1'b0;
  endtask

  task automatic test_clear();
    m_ready = 1'b0;
    load(8'hB0, 8);
    for (int i = 0; i < 10 && level != 2'd2; i++) step();
    tests++;
    if (level !== 2'd2 || tb_inflight !== 1'b1 || fifo_rd_en !== 1'b0) begin
      fails++;
      $display("FAIL clr_setup: level=%0d inflight=%b rd_en=%b, required 2 1 0", level, tb_inflight, fifo_rd_en);
    end
    clear = 1'b1;
    #1;
    tests++;
    if (fifo_rd_en !== 1'b0) begin
      fails++; $display("FAIL clr_rd_en: got %b, required 0", fifo_rd_en);
    end
    step();
    clear = 1'b0;
    tests++;
    if (m_valid !== 1'b0 || level !== 2'd0) begin
      fails++; $display("FAIL clr_flush: valid=%b level=%0d, required 0 0", m_valid, level);
    end
    resync();
    mark();
    m_ready = 1'b1;
    drain(40, "clr");
    tests++;
    if (hs_cnt != 5) begin
      fails++; $display("FAIL clr_survivors: got %0d beats, required 5", hs_cnt);
    end
  endtask

  task automatic test_async_reset();
    m_ready = 1'b1;
    load(8'hC0, 10);
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    #1;
    tests++;
    if ({m_valid, m_data, m_last, fifo_rd_en, level} !== '0) begin
      fails++;
      $display("FAIL async_rst: valid=%b data=%h last=%b rd_en=%b level=%0d, required all 0",
               m_valid, m_data, m_last, fifo_rd_en, level);
    end
    rst = 1'b0;
    tb_inflight = 1'b0;
    #1;
    resync();
    mark();
    drain(40, "rst");
    tests++;
    if (hs_cnt != 6 || last_cnt != 1) begin
      fails++; $display("FAIL rst_resume: beats=%0d lasts=%0d, required 6 1", hs_cnt, last_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_alternate();
    test_clear();
    test_async_reset();
    step(); step();
    tests++;
    if (sb.size() != 0 || m_valid !== 1'b0) begin
      fails++; $display("FAIL final_idle: outstanding=%0d valid=%b, required 0 0", sb.size(), m_valid);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
